transaction_forwarder: RTL and testbench

Downstream stage of the MemorEDF scheduler. On each scheduler `enable` pulse, it pops the head packet of queue `id` and forwards it on a valid/ready master port. On handshake completion it returns a one-cycle `consumed` pulse, which closes the scheduler's pending transaction. Exactly one transaction is in flight at a time.

---
 rtl/transaction_forwarder.sv | 141 ++++++++++++++
 tb/tb_transaction_forwarder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/transaction_forwarder.sv
// Pops one packet from a granted queue and forwards it on a valid/ready master port.
// Optional per-queue forwarded-packet counters are built when FORWARDER_STATS_EN is defined.
module transaction_forwarder #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int PACKET_SIZE      = 64,
  parameter int COUNTER_SIZE     = 32
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     enable,
  input  logic [$clog2(NUMBER_OF_QUEUES)-1:0]      id,
  input  logic [NUMBER_OF_QUEUES-1:0]              empty,
  input  logic [NUMBER_OF_QUEUES*PACKET_SIZE-1:0]  queue_data,
  output logic [NUMBER_OF_QUEUES-1:0]              pop,
  output logic                                     m_valid,
  input  logic                                     m_ready,
  output logic [PACKET_SIZE-1:0]                   m_data,
  output logic [$clog2(NUMBER_OF_QUEUES)-1:0]      m_id,
  output logic                                     consumed,
  output logic                                     busy,
  output logic                                     underflow,
  input  logic                                     stats_clear,
  output logic [NUMBER_OF_QUEUES*COUNTER_SIZE-1:0] stats
);

  localparam int ID_W = $clog2(NUMBER_OF_QUEUES);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t                      state_reg, state_next;
  logic [NUMBER_OF_QUEUES-1:0] pop_reg, pop_next;
  logic [PACKET_SIZE-1:0]      m_data_reg, m_data_next;
  logic [ID_W-1:0]             m_id_reg, m_id_next;
  logic                        m_valid_reg, m_valid_next;
  logic                        consumed_reg, consumed_next;
  logic                        busy_reg, busy_next;
  logic                        underflow_reg, underflow_next;

  logic [PACKET_SIZE-1:0] queue_data_arr [NUMBER_OF_QUEUES];

  genvar gi;
  generate
    for (gi = 0; gi < NUMBER_OF_QUEUES; gi++) begin : g_unpack
      assign queue_data_arr[gi] = queue_data[gi*PACKET_SIZE +: PACKET_SIZE];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      pop_reg       <= '0;
      m_data_reg    <= '0;
      m_id_reg      <= '0;
      m_valid_reg   <= 1'b0;
      consumed_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pop_reg       <= pop_next;
      m_data_reg    <= m_data_next;
      m_id_reg      <= m_id_next;
      m_valid_reg   <= m_valid_next;
      consumed_reg  <= consumed_next;
      busy_reg      <= busy_next;
      underflow_reg <= underflow_next;
    end
  end

  // Output registers are loaded from the upcoming state so every strobe
  // lines up with the state it belongs to without any input-to-output path.
  always_comb begin
    state_next     = state_reg;
    pop_next       = '0;
    m_data_next    = m_data_reg;
    m_id_next      = m_id_reg;
    underflow_next = underflow_reg;
    case (state_reg)
      IDLE: begin
        if (enable) begin
          if (empty[id]) begin
            underflow_next = 1'b1;
            state_next     = DONE;
          end else begin
            m_id_next    = id;
            pop_next[id] = 1'b1;
            state_next   = LOAD;
          end
        end
      end
      LOAD: begin
        m_data_next = queue_data_arr[m_id_reg];
        state_next  = SEND;
      end
      SEND: begin
        if (m_ready) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    m_valid_next  = (state_next == SEND);
    consumed_next = (state_next == DONE);
    busy_next     = (state_next != IDLE);
  end

  assign pop       = pop_reg;
  assign m_valid   = m_valid_reg;
  assign m_data    = m_data_reg;
  assign m_id      = m_id_reg;
  assign consumed  = consumed_reg;
  assign busy      = busy_reg;
  assign underflow = underflow_reg;

`ifdef FORWARDER_STATS_EN
  generate
    for (gi = 0; gi < NUMBER_OF_QUEUES; gi++) begin : g_stats
      logic [COUNTER_SIZE-1:0] count_reg;
      // Clear takes priority over a same-cycle handshake.
      always_ff @(posedge clock) begin
        if (reset || stats_clear) begin
          count_reg <= '0;
        end else if (state_reg == SEND && m_ready && m_id_reg == ID_W'(gi)) begin
          count_reg <= count_reg + COUNTER_SIZE'(1);
        end
      end
      assign stats[gi*COUNTER_SIZE +: COUNTER_SIZE] = count_reg;
    end
  endgenerate
`else
  logic unused_stats_clear;
  assign unused_stats_clear = stats_clear;
  assign stats              = '0;
`endif

endmodule

// File: tb/tb_transaction_forwarder.sv
// Directed bench for transaction_forwarder with a transaction-timing model checked every cycle.
module tb_transaction_forwarder;
  localparam int NQ = 4;
  localparam int PS = 64;
  localparam int CS = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic [1:0]        id;
  logic [NQ-1:0]     empty;
  logic [NQ*PS-1:0]  queue_data;
  logic [NQ-1:0]     pop;
  logic              m_valid;
  logic              m_ready;
  logic [PS-1:0]     m_data;
  logic [1:0]        m_id;
  logic              consumed;
  logic              busy;
  logic              underflow;
  logic              stats_clear;
  logic [NQ*CS-1:0]  stats;

  logic [PS-1:0] qdata [NQ];

  int tests = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clock = ~clock;

  always_comb begin
    queue_data = '0;
    for (int i = 0; i < NQ; i++) queue_data[i*PS +: PS] = qdata[i];
  end

  transaction_forwarder #(
    .NUMBER_OF_QUEUES(NQ), .PACKET_SIZE(PS), .COUNTER_SIZE(CS)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .id(id), .empty(empty),
    .queue_data(queue_data), .pop(pop), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_id(m_id), .consumed(consumed), .busy(busy),
    .underflow(underflow), .stats_clear(stats_clear), .stats(stats)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: mdl_t is the index (relative to the grant cycle) of the current cycle, -1 when idle.
  int         mdl_t = -1;
  bit         mdl_dry = 0;
  bit         mdl_done = 0;
  logic [1:0] mdl_id = '0;
  logic [63:0] mdl_data = '0;
  bit         mdl_uf = 0;
  int         mdl_stats [NQ];

  always @(posedge clock) begin
    if (reset) begin
      mdl_t = -1; mdl_dry = 0; mdl_done = 0; mdl_id = '0; mdl_data = '0; mdl_uf = 0;
      for (int i = 0; i < NQ; i++) mdl_stats[i] = 0;
    end else begin
      if (mdl_t < 0) begin
        if (enable) begin
          mdl_t = 1;
          mdl_done = 0;
          mdl_dry = empty[id];
          if (empty[id]) mdl_uf = 1;
          else mdl_id = id;
        end
      end else if (mdl_dry || mdl_done) begin
        mdl_t = -1;
      end else begin
        if (mdl_t == 1) begin
          mdl_data = qdata[mdl_id];
        end else if (m_ready) begin
          mdl_done = 1;
`ifdef FORWARDER_STATS_EN
          mdl_stats[mdl_id] = (mdl_stats[mdl_id] + 1) % (1 << CS);
`endif
        end
        mdl_t++;
      end
      if (stats_clear) begin
        for (int i = 0; i < NQ; i++) mdl_stats[i] = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      logic [NQ-1:0]    e_pop;
      logic [NQ*CS-1:0] e_stats;
      e_pop = '0;
      if (mdl_t == 1 && !mdl_dry) e_pop[mdl_id] = 1'b1;
      for (int i = 0; i < NQ; i++) e_stats[i*CS +: CS] = mdl_stats[i][CS-1:0];
      check("pop", 64'(pop), 64'(e_pop));
      check("m_valid", 64'(m_valid), 64'(mdl_t >= 2 && !mdl_done && !mdl_dry));
      check("consumed", 64'(consumed), 64'(mdl_t >= 1 && (mdl_dry || mdl_done)));
      check("busy", 64'(busy), 64'(mdl_t >= 1));
      check("m_data", m_data, mdl_data);
      check("m_id", 64'(m_id), 64'(mdl_id));
      check("underflow", 64'(underflow), 64'(mdl_uf));
      check("stats", 64'(stats), 64'(e_stats));
    end
  end

  task automatic grant(input logic [1:0] q);
    @(negedge clock);
    enable = 1'b1;
    id = q;
    @(negedge clock);
    enable = 1'b0;
  endtask

`ifdef FORWARDER_STATS_EN
  localparam logic [CS-1:0] EXP17 = 4'd1;
`else
  localparam logic [CS-1:0] EXP17 = 4'd0;
`endif

  initial begin
    int pops, cons, nbusy, nvalid;
    reset = 1'b1; enable = 1'b0; id = '0; empty = '0; m_ready = 1'b1; stats_clear = 1'b0;
    for (int i = 0; i < NQ; i++) qdata[i] = 64'h1000 + 64'(i);
    repeat (2) @(negedge clock);
    check("reset_pop", 64'(pop), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_m_data", m_data, 64'h0);
    reset = 1'b0;
    chk_en = 1;

    // Basic transfer from queue 2
    qdata[2] = 64'hA5A5;
    grant(2'd2);
    check("t1_pop_c1", 64'(pop), 64'h4);
    @(negedge clock);
    check("t1_valid_c2", 64'(m_valid), 64'h1);
    check("t1_data_c2", m_data, 64'hA5A5);
    check("t1_id_c2", 64'(m_id), 64'h2);
    @(negedge clock);
    check("t1_consumed_c3", 64'(consumed), 64'h1);
    @(negedge clock);
    check("t1_consumed_c4", 64'(consumed), 64'h0);
    check("t1_busy_c4", 64'(busy), 64'h0);

    // Stall m_ready for 5 SEND cycles
    qdata[2] = 64'h5A5A_0102_0304_0506;
    m_ready = 1'b0;
    grant(2'd2);
    nbusy = int'(busy); nvalid = int'(m_valid); cons = 0;
    for (int c = 2; c <= 12; c++) begin
      @(negedge clock);
      if (c == 3) qdata[2] = 64'hDEAD;
      nbusy += int'(busy);
      nvalid += int'(m_valid);
      if (consumed) begin
        cons++;
        check("t2_consumed_cycle", 64'(c), 64'd8);
      end
      if (c == 7) m_ready = 1'b1;
    end
    check("t2_busy_cycles", 64'(nbusy), 64'd8);
    check("t2_valid_cycles", 64'(nvalid), 64'd6);
    check("t2_consumed_count", 64'(cons), 64'd1);

    // Grant for an empty queue
    empty = 4'b0010;
    grant(2'd1);
    check("t3_consumed_c1", 64'(consumed), 64'h1);
    check("t3_underflow_c1", 64'(underflow), 64'h1);
    check("t3_pop_c1", 64'(pop), 64'h0);
    check("t3_valid_c1", 64'(m_valid), 64'h0);
    @(negedge clock);
    check("t3_consumed_c2", 64'(consumed), 64'h0);
    check("t3_busy_c2", 64'(busy), 64'h0);
    empty = 4'b0000;

    // Second enable during SEND is ignored
    qdata[3] = 64'h3333_CAFE;
    qdata[0] = 64'h0000_BEEF;
    m_ready = 1'b0;
    grant(2'd3);
    pops = $countones(pop); cons = int'(consumed);
    for (int c = 2; c <= 8; c++) begin
      @(negedge clock);
      pops += $countones(pop);
      cons += int'(consumed);
      if (c == 2) begin enable = 1'b1; id = 2'd0; end
      if (c == 3) enable = 1'b0;
      if (c == 4) m_ready = 1'b1;
    end
    check("t4_pop_count", 64'(pops), 64'd1);
    check("t4_consumed_count", 64'(cons), 64'd1);
    check("t4_underflow_sticky", 64'(underflow), 64'h1);

    // Reset during SEND
    qdata[1] = 64'h1111_2222_3333_4444;
    m_ready = 1'b0;
    grant(2'd1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t5_valid", 64'(m_valid), 64'h0);
    check("t5_busy", 64'(busy), 64'h0);
    check("t5_consumed", 64'(consumed), 64'h0);
    check("t5_m_data", m_data, 64'h0);
    check("t5_underflow", 64'(underflow), 64'h0);
    reset = 1'b0;
    m_ready = 1'b1;
    cons = 0;
    repeat (3) begin
      @(negedge clock);
      cons += int'(consumed);
    end
    check("t5_no_consumed", 64'(cons), 64'd0);

    // 17 transfers from queue 0, then clear
    for (int n = 0; n < 17; n++) begin
      qdata[0] = 64'(n) * 64'h0101;
      grant(2'd0);
      repeat (3) @(negedge clock);
    end
    check("t6_stats0_after17", 64'(stats[CS-1:0]), 64'(EXP17));
    @(negedge clock);
    stats_clear = 1'b1;
    @(negedge clock);
    stats_clear = 1'b0;
    check("t6_stats0_cleared", 64'(stats[CS-1:0]), 64'h0);

    // Clear coinciding with a handshake
    grant(2'd0);
    @(negedge clock);
    stats_clear = 1'b1;
    @(negedge clock);
    stats_clear = 1'b0;
    check("t7_clear_wins", 64'(stats[CS-1:0]), 64'h0);
    repeat (3) @(negedge clock);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
